// File: rtl/mem_access_dcache_unit.sv
// MEM-stage unit of the RV32I pipeline.
// Aligns store data, extends load data, selects the register writeback value and
// holds a direct-mapped write-back / write-allocate data cache. Misses are served
// by a four-state FSM that exchanges whole blocks with main memory. The pipeline
// is stalled through data_memory_busywait while a miss is being served.
module mem_access_dcache_unit #(
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      mem_read_signal,
  input  logic                                      mem_write_signal,
  input  logic                                      mux5signal,
  input  logic [31:0]                               mux4_out_result,
  input  logic [31:0]                               data2,
  input  logic [2:0]                                func3,
  output logic                                      data_memory_busywait,
  output logic [31:0]                               mux5_out_write_data,
  output logic                                      mem_read,
  output logic                                      mem_write,
  output logic [ADDR_W-2-$clog2(BLOCK_WORDS)-1:0]   mem_address,
  output logic [32*BLOCK_WORDS-1:0]                 mem_writedata,
  input  logic [32*BLOCK_WORDS-1:0]                 mem_readdata,
  input  logic                                      mem_busywait
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int BLK_W  = ADDR_W - 2 - OFF_W;
  localparam int TAG_W  = BLK_W - IDX_W;
  localparam int OFF_SW = (OFF_W > 0) ? OFF_W : 1;
  localparam int LINE_W = 32 * BLOCK_WORDS;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE_BACK,
    S_MEM_READ,
    S_UPDATE
  } state_e;

  // Merge store data into an existing word according to the store width.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    case (f3)
      F3_B:    res[{lane, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    res = wdata;
      default: res = old_word;
    endcase
    return res;
  endfunction

  // Pick the addressed byte/half/word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_BU:   res = {24'd0, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_HU:   res = {16'd0, h};
      F3_W:    res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Cache storage: data and tags are never reset, only valid/dirty are.
  logic [31:0]       data_q [NUM_SETS][BLOCK_WORDS];
  logic [TAG_W-1:0]  tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
  logic [LINE_W-1:0] fill_q;

  // Request address decode.
  logic [BLK_W-1:0]  blk_a;
  logic [IDX_W-1:0]  idx_a;
  logic [TAG_W-1:0]  tag_a;
  logic [OFF_SW-1:0] woff_a;
  logic [1:0]        lane_a;

  assign blk_a  = mux4_out_result[ADDR_W-1:2+OFF_W];
  assign idx_a  = blk_a[IDX_W-1:0];
  assign tag_a  = blk_a[BLK_W-1:IDX_W];
  assign lane_a = mux4_out_result[1:0];

  generate
    if (OFF_W > 0) begin : g_off
      assign woff_a = mux4_out_result[2 +: OFF_SW];
    end else begin : g_nooff
      assign woff_a = '0;
    end
  endgenerate

  // A write with an unknown width code is dropped and never stalls; a request
  // with both read and write high is served as a write.
  logic wr_req, rd_req, access, hit;
  logic [31:0] rd_word;

  assign wr_req  = mem_write_signal && ((func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W));
  assign rd_req  = mem_read_signal && !mem_write_signal;
  assign access  = wr_req || rd_req;
  assign hit     = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
  assign rd_word = data_q[idx_a][woff_a];

  logic busy_c;
  logic store_hit;
  logic fill_cap;
  logic line_upd;

  // Miss FSM: next state, stall and main-memory request generation.
  always_comb begin
    state_d     = state_q;
    miss_tag_d  = miss_tag_q;
    miss_idx_d  = miss_idx_q;
    busy_c      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    store_hit   = 1'b0;
    fill_cap    = 1'b0;
    line_upd    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (hit) begin
            store_hit = wr_req;
          end else begin
            busy_c     = 1'b1;
            miss_tag_d = tag_a;
            miss_idx_d = idx_a;
            state_d    = (valid_q[idx_a] && dirty_q[idx_a]) ? S_WRITE_BACK : S_MEM_READ;
          end
        end
      end
      S_WRITE_BACK: begin
        busy_c      = 1'b1;
        mem_write   = 1'b1;
        mem_address = {tag_q[miss_idx_q], miss_idx_q};
        if (!mem_busywait) state_d = S_MEM_READ;
      end
      S_MEM_READ: begin
        busy_c      = 1'b1;
        mem_read    = 1'b1;
        mem_address = {miss_tag_q, miss_idx_q};
        if (!mem_busywait) begin
          fill_cap = 1'b1;
          state_d  = S_UPDATE;
        end
      end
      S_UPDATE: begin
        busy_c   = 1'b1;
        line_upd = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register; reset abandons any transfer in flight.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Miss address capture (datapath, no reset needed).
  always_ff @(posedge clock) begin
    miss_tag_q <= miss_tag_d;
    miss_idx_q <= miss_idx_d;
  end

  // Line status bits: store hits mark dirty, a refill leaves the line clean.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (store_hit) dirty_q[idx_a] <= 1'b1;
      if (line_upd) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
    end
  end

  // Data, tag and fill buffer updates.
  always_ff @(posedge clock) begin
    if (fill_cap) fill_q <= mem_readdata;
    if (store_hit) data_q[idx_a][woff_a] <= store_merge(rd_word, data2, func3, lane_a);
    if (line_upd) begin
      tag_q[miss_idx_q] <= miss_tag_q;
      for (int w = 0; w < BLOCK_WORDS; w++) begin
        data_q[miss_idx_q][w] <= fill_q[32*w +: 32];
      end
    end
  end

  // Victim line presented to main memory, word 0 in the LSBs.
  always_comb begin
    mem_writedata = '0;
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      mem_writedata[32*w +: 32] = data_q[miss_idx_q][w];
    end
  end

  logic [31:0] ld_data;

  assign ld_data              = (rd_req && !busy_c) ? load_extend(rd_word, func3, lane_a) : 32'd0;
  assign data_memory_busywait = busy_c;
  assign mux5_out_write_data  = mux5signal ? ld_data : mux4_out_result;

endmodule

// File: tb/tb_mem_access_dcache_unit.sv
// Directed bench for mem_access_dcache_unit with a block-memory model whose
// latency is LAT cycles of mem_busywait=1 per transfer.
module tb_mem_access_dcache_unit;

  localparam int LAT = 5;

  logic         clock = 1'b0;
  logic         reset;
  logic         mem_read_signal, mem_write_signal, mux5signal;
  logic [31:0]  mux4_out_result, data2;
  logic [2:0]   func3;
  logic         data_memory_busywait;
  logic [31:0]  mux5_out_write_data;
  logic         mem_read, mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int compared = 0;
  int mismatched = 0;

  mem_access_dcache_unit #(.NUM_SETS(8), .BLOCK_WORDS(4), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .mem_read_signal(mem_read_signal), .mem_write_signal(mem_write_signal),
    .mux5signal(mux5signal), .mux4_out_result(mux4_out_result), .data2(data2),
    .func3(func3), .data_memory_busywait(data_memory_busywait),
    .mux5_out_write_data(mux5_out_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  // Main-memory model: counts latency, logs completed transfers, stores write-backs.
  int           lat_cnt = 0;
  int           cyc = 0;
  int           rd_xfers = 0, wr_xfers = 0, rd_cyc = 0, wr_cyc = 0, both_hi = 0;
  logic [27:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;
  logic [127:0] bmem [64];
  bit           bval [64];

  assign mem_busywait = (mem_read || mem_write) && (lat_cnt < LAT);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_read && mem_write) both_hi <= both_hi + 1;
    if (!(mem_read || mem_write) || !mem_busywait) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
    if (mem_read && !mem_busywait) begin
      rd_xfers <= rd_xfers + 1; last_rd_addr <= mem_address; rd_cyc <= cyc;
    end
    if (mem_write && !mem_busywait) begin
      wr_xfers <= wr_xfers + 1; last_wr_addr <= mem_address; last_wr_data <= mem_writedata;
      wr_cyc <= cyc; bmem[mem_address[5:0]] <= mem_writedata; bval[mem_address[5:0]] <= 1'b1;
    end
  end

  // Unwritten blocks read back as 0xA5000000 | byte address of each word.
  always_comb begin
    mem_readdata = '0;
    if (bval[mem_address[5:0]]) mem_readdata = bmem[mem_address[5:0]];
    else for (int w = 0; w < 4; w++)
      mem_readdata[32*w +: 32] = 32'hA500_0000 | ({4'd0, mem_address} << 4) | 32'(4*w);
  end

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic m5);
    @(posedge clock); #1;
    mem_read_signal = rd; mem_write_signal = wr; func3 = f3;
    mux4_out_result = a; data2 = d; mux5signal = m5;
  endtask

  task automatic wait_free(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!data_memory_busywait) return;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_read_signal = 0; mem_write_signal = 0; mux5signal = 0;
    mux4_out_result = 32'h1234; data2 = 0; func3 = LW;
    repeat (3) @(posedge clock);
    @(negedge clock);
    compared++; if (mem_read !== 1'b0) begin mismatched++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
    compared++; if (mem_write !== 1'b0) begin mismatched++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
    compared++; if (data_memory_busywait !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", data_memory_busywait); end
    compared++; if (mux5_out_write_data !== 32'h1234) begin mismatched++; $display("FAIL rst_wb: got %h want 00001234", mux5_out_write_data); end
    reset = 1'b0;
  endtask

  task automatic test_cold_miss;
    int n, r0;
    r0 = rd_xfers;
    drive(1, 0, LW, 32'h40, 0, 1); #2;
    compared++; if (data_memory_busywait !== 1'b1) begin mismatched++; $display("FAIL cold_busy_first: got %b want 1", data_memory_busywait); end
    compared++; if (mux5_out_write_data !== 32'h0) begin mismatched++; $display("FAIL cold_wb_while_busy: got %h want 0", mux5_out_write_data); end
    wait_free(n);
    compared++; if (n !== 8) begin mismatched++; $display("FAIL cold_busy_cycles: got %0d want 8", n); end
    compared++; if (rd_xfers - r0 !== 1) begin mismatched++; $display("FAIL cold_rd_count: got %0d want 1", rd_xfers - r0); end
    compared++; if (last_rd_addr !== 28'h4) begin mismatched++; $display("FAIL cold_rd_addr: got %h want 4", last_rd_addr); end
    compared++; if (mux5_out_write_data !== 32'hA500_0040) begin mismatched++; $display("FAIL cold_hit_data: got %h want a5000040", mux5_out_write_data); end
    compared++; if (mem_read !== 1'b0) begin mismatched++; $display("FAIL cold_mem_read_idle: got %b want 0", mem_read); end
  endtask

  task automatic test_store_byte;
    drive(0, 1, LB, 32'h41, 32'h1234_56AB, 1); #2;
    compared++; if (data_memory_busywait !== 1'b0) begin mismatched++; $display("FAIL sb_stall: got %b want 0", data_memory_busywait); end
    drive(1, 0, LB, 32'h41, 0, 1); #2;
    compared++; if (data_memory_busywait !== 1'b0) begin mismatched++; $display("FAIL lb_stall: got %b want 0", data_memory_busywait); end
    compared++; if (mux5_out_write_data !== 32'hFFFF_FFAB) begin mismatched++; $display("FAIL lb_41: got %h want ffffffab", mux5_out_write_data); end
    drive(1, 0, LBU, 32'h41, 0, 1); #2;
    compared++; if (mux5_out_write_data !== 32'h0000_00AB) begin mismatched++; $display("FAIL lbu_41: got %h want 000000ab", mux5_out_write_data); end
  endtask

  task automatic test_store_half;
    drive(0, 1, LH, 32'h42, 32'hDEAD_8001, 1); #2;
    compared++; if (data_memory_busywait !== 1'b0) begin mismatched++; $display("FAIL sh_stall: got %b want 0", data_memory_busywait); end
    drive(1, 0, LH, 32'h42, 0, 1); #2;
    compared++; if (mux5_out_write_data !== 32'hFFFF_8001) begin mismatched++; $display("FAIL lh_42: got %h want ffff8001", mux5_out_write_data); end
    drive(1, 0, LHU, 32'h42, 0, 1); #2;
    compared++; if (mux5_out_write_data !== 32'h0000_8001) begin mismatched++; $display("FAIL lhu_42: got %h want 00008001", mux5_out_write_data); end
    drive(1, 0, LW, 32'h40, 0, 1); #2;
    compared++; if (mux5_out_write_data !== 32'h8001_AB40) begin mismatched++; $display("FAIL lw_40: got %h want 8001ab40", mux5_out_write_data); end
    drive(1, 0, LH, 32'h40, 0, 1); #2;
    compared++; if (mux5_out_write_data !== 32'hFFFF_AB40) begin mismatched++; $display("FAIL lh_40: got %h want ffffab40", mux5_out_write_data); end
    drive(1, 0, LB, 32'h43, 0, 1); #2;
    compared++; if (mux5_out_write_data !== 32'hFFFF_FF80) begin mismatched++; $display("FAIL lb_43: got %h want ffffff80", mux5_out_write_data); end
  endtask

  task automatic test_dirty_evict;
    int n, r0, w0;
    r0 = rd_xfers; w0 = wr_xfers;
    drive(1, 0, LW, 32'hC0, 0, 1);
    wait_free(n);
    compared++; if (n !== 14) begin mismatched++; $display("FAIL evict_busy_cycles: got %0d want 14", n); end
    compared++; if (wr_xfers - w0 !== 1) begin mismatched++; $display("FAIL evict_wr_count: got %0d want 1", wr_xfers - w0); end
    compared++; if (rd_xfers - r0 !== 1) begin mismatched++; $display("FAIL evict_rd_count: got %0d want 1", rd_xfers - r0); end
    compared++; if (last_wr_addr !== 28'h4) begin mismatched++; $display("FAIL evict_wr_addr: got %h want 4", last_wr_addr); end
    compared++; if (last_wr_data !== 128'hA500004C_A5000048_A5000044_8001AB40) begin mismatched++; $display("FAIL evict_wr_data: got %h want a500004ca5000048a50000448001ab40", last_wr_data); end
    compared++; if (last_rd_addr !== 28'hC) begin mismatched++; $display("FAIL evict_rd_addr: got %h want c", last_rd_addr); end
    compared++; if (!(wr_cyc < rd_cyc)) begin mismatched++; $display("FAIL evict_order: wr at %0d rd at %0d, want write first", wr_cyc, rd_cyc); end
    compared++; if (mux5_out_write_data !== 32'hA500_00C0) begin mismatched++; $display("FAIL evict_hit_data: got %h want a50000c0", mux5_out_write_data); end
    w0 = wr_xfers;
    drive(1, 0, LW, 32'h40, 0, 1);
    wait_free(n);
    compared++; if (n !== 8) begin mismatched++; $display("FAIL clean_evict_cycles: got %0d want 8", n); end
    compared++; if (wr_xfers !== w0) begin mismatched++; $display("FAIL clean_evict_no_wb: got %0d writes want %0d", wr_xfers, w0); end
    compared++; if (mux5_out_write_data !== 32'h8001_AB40) begin mismatched++; $display("FAIL refetch_wb_data: got %h want 8001ab40", mux5_out_write_data); end
  endtask

  task automatic test_reset_mid;
    int n, r0;
    r0 = rd_xfers;
    drive(1, 0, LW, 32'h100, 0, 1);
    @(posedge clock); #2;
    compared++; if (mem_read !== 1'b1) begin mismatched++; $display("FAIL mid_mem_read_active: got %b want 1", mem_read); end
    drive(0, 0, LW, 32'h100, 0, 1);
    reset = 1'b1;
    @(posedge clock); #2;
    compared++; if (mem_read !== 1'b0) begin mismatched++; $display("FAIL mid_rst_mem_read: got %b want 0", mem_read); end
    compared++; if (data_memory_busywait !== 1'b0) begin mismatched++; $display("FAIL mid_rst_busy: got %b want 0", data_memory_busywait); end
    compared++; if (rd_xfers !== r0) begin mismatched++; $display("FAIL mid_rst_no_xfer: got %0d want %0d", rd_xfers, r0); end
    reset = 1'b0;
    r0 = rd_xfers;
    drive(1, 0, LW, 32'h40, 0, 1);
    wait_free(n);
    compared++; if (n !== 8) begin mismatched++; $display("FAIL post_rst_miss_cycles: got %0d want 8", n); end
    compared++; if (rd_xfers - r0 !== 1) begin mismatched++; $display("FAIL post_rst_rd_count: got %0d want 1", rd_xfers - r0); end
    compared++; if (mux5_out_write_data !== 32'h8001_AB40) begin mismatched++; $display("FAIL post_rst_data: got %h want 8001ab40", mux5_out_write_data); end
    drive(1, 0, LW, 32'h100, 0, 1);
    wait_free(n);
    compared++; if (n !== 8) begin mismatched++; $display("FAIL post_rst_100_cycles: got %0d want 8", n); end
    compared++; if (mux5_out_write_data !== 32'hA500_0100) begin mismatched++; $display("FAIL post_rst_100_data: got %h want a5000100", mux5_out_write_data); end
  endtask

  task automatic test_wb_mux_and_rw;
    int w0, r0;
    drive(0, 0, LW, 32'h1234, 0, 0); #2;
    compared++; if (mux5_out_write_data !== 32'h1234) begin mismatched++; $display("FAIL alu_wb: got %h want 00001234", mux5_out_write_data); end
    compared++; if (data_memory_busywait !== 1'b0) begin mismatched++; $display("FAIL alu_busy: got %b want 0", data_memory_busywait); end
    drive(0, 0, LW, 32'h40, 0, 1); #2;
    compared++; if (mux5_out_write_data !== 32'h0) begin mismatched++; $display("FAIL noread_wb: got %h want 0", mux5_out_write_data); end
    drive(1, 1, LW, 32'h40, 32'h5555_AAAA, 1); #2;
    compared++; if (data_memory_busywait !== 1'b0) begin mismatched++; $display("FAIL rw_busy: got %b want 0", data_memory_busywait); end
    compared++; if (mux5_out_write_data !== 32'h0) begin mismatched++; $display("FAIL rw_load_zero: got %h want 0", mux5_out_write_data); end
    drive(1, 0, LW, 32'h40, 0, 1); #2;
    compared++; if (mux5_out_write_data !== 32'h5555_AAAA) begin mismatched++; $display("FAIL rw_store_done: got %h want 5555aaaa", mux5_out_write_data); end
    w0 = wr_xfers; r0 = rd_xfers;
    drive(0, 1, 3'b011, 32'h300, 32'hFFFF_FFFF, 1); #2;
    compared++; if (data_memory_busywait !== 1'b0) begin mismatched++; $display("FAIL badf3_wr_busy: got %b want 0", data_memory_busywait); end
    drive(1, 0, 3'b011, 32'h40, 0, 1); #2;
    compared++; if (mux5_out_write_data !== 32'h0) begin mismatched++; $display("FAIL badf3_rd_data: got %h want 0", mux5_out_write_data); end
    compared++; if ((wr_xfers !== w0) || (rd_xfers !== r0)) begin mismatched++; $display("FAIL badf3_no_xfer: got wr %0d rd %0d want %0d %0d", wr_xfers, rd_xfers, w0, r0); end
    drive(0, 0, LW, 32'h0, 0, 0);
    @(negedge clock);
    compared++; if (both_hi !== 0) begin mismatched++; $display("FAIL rd_wr_exclusive: got %0d cycles both high want 0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_store_byte();
    test_store_half();
    test_dirty_evict();
    test_reset_mid();
    test_wb_mux_and_rw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
